// File: rtl/fetch_queue_if.sv
// ---------------------------------------------------------------------------
// fetch_queue_if
// Groups the fetch-side and decode-side handshake signals of the fetch queue.
//
// Fetch side : imem_addr_F, instr_F, valid_F (producer -> queue), ready_F
//              (queue -> producer).
// Decode side: pc_D, instr_D, valid_D (queue -> consumer), ready_D
//              (consumer -> queue), flush_D (taken branch, discards the queue).
// Status     : count_Q, number of valid entries held.
//
// The master modport is the environment around the queue (fetch + decode);
// the slave modport is the queue itself.
// ---------------------------------------------------------------------------
interface fetch_queue_if #(
   parameter int CW = 3
);

   logic [63:0]   imem_addr_F;
   logic [31:0]   instr_F;
   logic          valid_F;
   logic          ready_F;
   logic          flush_D;
   logic [63:0]   pc_D;
   logic [31:0]   instr_D;
   logic          valid_D;
   logic          ready_D;
   logic [CW-1:0] count_Q;

   modport master (
      output imem_addr_F, instr_F, valid_F, flush_D, ready_D,
      input  ready_F, pc_D, instr_D, valid_D, count_Q
   );

   modport slave (
      input  imem_addr_F, instr_F, valid_F, flush_D, ready_D,
      output ready_F, pc_D, instr_D, valid_D, count_Q
   );

endinterface

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
// Small first-word-fall-through FIFO between instruction fetch and decode.
// Each entry is a {PC, instruction} pair. A taken branch (flush_D) throws
// away everything queued at the next rising edge.
//
// Parameters
//   DEPTH : number of entries, power of two in 2..16
//   CW    : width of count_Q, log2(DEPTH)+1
//
// Ports
//   clk   : single clock, all state updates on the rising edge
//   reset : asynchronous, active-high; empties the queue immediately
//   bus   : fetch_queue_if.slave carrying the fetch/decode handshakes
//
// Behaviour summary
//   - push when valid_F & ready_F & !flush_D, pop when valid_D & ready_D &
//     !flush_D
//   - ready_F only looks at the occupancy, never at ready_D, so a full queue
//     refuses a push even in a cycle where decode is popping
//   - the head entry drives pc_D/instr_D combinationally; both read as zero
//     whenever the queue is empty, so stale storage is never visible
// ---------------------------------------------------------------------------
module fetch_queue #(
   parameter int DEPTH = 4,
   parameter int CW    = 3
) (
   input  logic         clk,
   input  logic         reset,
   fetch_queue_if.slave bus
);

   localparam int AW = $clog2(DEPTH);

   logic [63:0]   pc_mem    [DEPTH];
   logic [31:0]   instr_mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          has_room;
   logic          not_empty;
   logic          push;
   logic          pop;
   logic [63:0]   head_pc;
   logic [31:0]   head_instr;

   // Occupancy flags come straight from the entry counter. A flush in the
   // current cycle does not change them: the pre-flush state stays visible
   // until the edge that performs the flush.
   assign has_room  = (count < CW'(DEPTH));
   assign not_empty = (count != '0);

   // A flush overrides both transfer directions for the cycle it is raised.
   assign push = bus.valid_F && has_room  && !bus.flush_D;
   assign pop  = bus.ready_D && not_empty && !bus.flush_D;

   // Pointer and counter state. Reset and flush both realign the pointers
   // to slot 0 so the queue always restarts from a known position. The
   // pointers are exactly log2(DEPTH) bits wide so incrementing them wraps
   // modulo DEPTH with no extra logic.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (bus.flush_D) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         unique case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Entry storage. It is deliberately not reset or cleared on flush: an
   // entry only becomes observable once the counter says it is valid, and
   // by then it has been written by a push.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr]    <= bus.imem_addr_F;
         instr_mem[wr_ptr] <= bus.instr_F;
      end
   end

   // Head-of-queue read. There is no bypass from the fetch inputs, so a
   // freshly pushed entry only shows up after the edge that stored it.
   // Outputs are forced to zero when empty to hide stale storage.
   always_comb begin
      head_pc    = 64'd0;
      head_instr = 32'd0;
      if (not_empty) begin
         head_pc    = pc_mem[rd_ptr];
         head_instr = instr_mem[rd_ptr];
      end
   end

   assign bus.ready_F = has_room;
   assign bus.valid_D = not_empty;
   assign bus.pc_D    = head_pc;
   assign bus.instr_D = head_instr;
   assign bus.count_Q = count;

endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
// Self-checking bench for fetch_queue. A queue of {pc, instr} entries acts as
// the reference: pushes append, pops remove the front, flush and reset empty
// it, and a push is refused whenever the reference already holds DEPTH
// entries. Directed scenarios check against literal expected values;
// the random scenario checks every cycle against the reference queue.
// ---------------------------------------------------------------------------
module tb_fetch_queue;

   localparam int          DEPTH      = 4;
   localparam int          CW         = 3;
   localparam logic [31:0] INSTR_BASE = 32'h8B02_0020;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] instr;
   } entry_t;

   logic   clk = 1'b0;
   logic   reset;
   int     n_checks = 0;
   int     n_fail   = 0;
   entry_t model_q[$];

   fetch_queue_if #(.CW(CW)) bus ();

   fetch_queue #(
      .DEPTH(DEPTH),
      .CW   (CW)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.slave)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   // Guard against any accidental hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [63:0] exp_pc();
      return (model_q.size() > 0) ? model_q[0].pc : 64'd0;
   endfunction

   function automatic logic [31:0] exp_instr();
      return (model_q.size() > 0) ? model_q[0].instr : 32'd0;
   endfunction

   // Drive one cycle of directed stimulus; instruction is derived from PC.
   task automatic drive(input logic v, input logic [63:0] a, input logic r, input logic f);
      bus.valid_F     = v;
      bus.imem_addr_F = a;
      bus.instr_F     = INSTR_BASE + a[31:0];
      bus.ready_D     = r;
      bus.flush_D     = f;
   endtask

   // Advance one clock and update the reference from the inputs seen there.
   task automatic cycle();
      bit     do_push;
      bit     do_pop;
      entry_t e;
      do_push = bus.valid_F && (model_q.size() < DEPTH) && !bus.flush_D;
      do_pop  = bus.ready_D && (model_q.size() > 0) && !bus.flush_D;
      e.pc    = bus.imem_addr_F;
      e.instr = bus.instr_F;
      @(posedge clk);
      if (reset || bus.flush_D) begin
         model_q.delete();
      end else begin
         if (do_pop)  void'(model_q.pop_front());
         if (do_push) model_q.push_back(e);
      end
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(1'b0, 64'd0, 1'b0, 1'b0);
      #1;
      n_checks++; if (bus.count_Q !== 3'd0) begin n_fail++; $display("[TB] FAIL reset_count: got %0d expected 0", bus.count_Q); end
      n_checks++; if (bus.valid_D !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid_D: got %b expected 0", bus.valid_D); end
      n_checks++; if (bus.ready_F !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready_F: got %b expected 1", bus.ready_F); end
      n_checks++; if (bus.pc_D !== 64'd0) begin n_fail++; $display("[TB] FAIL reset_pc_D: got %0h expected 0", bus.pc_D); end
      n_checks++; if (bus.instr_D !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_instr_D: got %0h expected 0", bus.instr_D); end
      // Pushes are ignored while reset is held.
      drive(1'b1, 64'h40, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      n_checks++; if (bus.count_Q !== 3'd0) begin n_fail++; $display("[TB] FAIL reset_hold_count: got %0d expected 0", bus.count_Q); end
      drive(1'b0, 64'd0, 1'b0, 1'b0);
      #2;
      reset = 1'b0;
      @(posedge clk);
      #1;
      model_q.delete();
   endtask

   task automatic test_fill();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 64'(4 * i), 1'b0, 1'b0);
         cycle();
      end
      n_checks++; if (bus.count_Q !== 3'd4) begin n_fail++; $display("[TB] FAIL fill_count: got %0d expected 4", bus.count_Q); end
      n_checks++; if (bus.ready_F !== 1'b0) begin n_fail++; $display("[TB] FAIL fill_ready_F: got %b expected 0", bus.ready_F); end
      n_checks++; if (bus.pc_D !== 64'd0) begin n_fail++; $display("[TB] FAIL fill_head_pc: got %0h expected 0", bus.pc_D); end
      n_checks++; if (bus.instr_D !== INSTR_BASE) begin n_fail++; $display("[TB] FAIL fill_head_instr: got %0h expected %0h", bus.instr_D, INSTR_BASE); end
      drive(1'b1, 64'd16, 1'b0, 1'b0);
      cycle();
      n_checks++; if (bus.count_Q !== 3'd4) begin n_fail++; $display("[TB] FAIL fill_overflow_count: got %0d expected 4", bus.count_Q); end
      n_checks++; if (bus.pc_D !== 64'd0) begin n_fail++; $display("[TB] FAIL fill_overflow_pc: got %0h expected 0", bus.pc_D); end
   endtask

   task automatic test_drain();
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 64'd0, 1'b1, 1'b0);
         n_checks++; if (bus.valid_D !== 1'b1) begin n_fail++; $display("[TB] FAIL drain_valid_%0d: got %b expected 1", i, bus.valid_D); end
         n_checks++; if (bus.pc_D !== 64'(4 * i)) begin n_fail++; $display("[TB] FAIL drain_pc_%0d: got %0h expected %0h", i, bus.pc_D, 4 * i); end
         n_checks++; if (bus.instr_D !== INSTR_BASE + 32'(4 * i)) begin n_fail++; $display("[TB] FAIL drain_instr_%0d: got %0h expected %0h", i, bus.instr_D, INSTR_BASE + 32'(4 * i)); end
         cycle();
      end
      n_checks++; if (bus.valid_D !== 1'b0) begin n_fail++; $display("[TB] FAIL drain_end_valid: got %b expected 0", bus.valid_D); end
      n_checks++; if (bus.pc_D !== 64'd0) begin n_fail++; $display("[TB] FAIL drain_end_pc: got %0h expected 0", bus.pc_D); end
      n_checks++; if (bus.instr_D !== 32'd0) begin n_fail++; $display("[TB] FAIL drain_end_instr: got %0h expected 0", bus.instr_D); end
      n_checks++; if (bus.count_Q !== 3'd0) begin n_fail++; $display("[TB] FAIL drain_end_count: got %0d expected 0", bus.count_Q); end
   endtask

   task automatic test_streaming();
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 64'(4 * i), 1'b1, 1'b0);
         cycle();
         n_checks++; if (bus.count_Q !== 3'd1) begin n_fail++; $display("[TB] FAIL stream_count_%0d: got %0d expected 1", i, bus.count_Q); end
         n_checks++; if (bus.pc_D !== 64'(4 * i)) begin n_fail++; $display("[TB] FAIL stream_pc_%0d: got %0h expected %0h", i, bus.pc_D, 4 * i); end
      end
      drive(1'b0, 64'd0, 1'b1, 1'b0);
      cycle();
      n_checks++; if (bus.count_Q !== 3'd0) begin n_fail++; $display("[TB] FAIL stream_end_count: got %0d expected 0", bus.count_Q); end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 64'(100 + 4 * i), 1'b0, 1'b0);
         cycle();
      end
      n_checks++; if (bus.count_Q !== 3'd3) begin n_fail++; $display("[TB] FAIL flush_pre_count: got %0d expected 3", bus.count_Q); end
      drive(1'b1, 64'd112, 1'b1, 1'b1);
      #1;
      n_checks++; if (bus.pc_D !== 64'd100) begin n_fail++; $display("[TB] FAIL flush_cycle_pc: got %0d expected 100", bus.pc_D); end
      n_checks++; if (bus.valid_D !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_cycle_valid: got %b expected 1", bus.valid_D); end
      cycle();
      n_checks++; if (bus.count_Q !== 3'd0) begin n_fail++; $display("[TB] FAIL flush_count: got %0d expected 0", bus.count_Q); end
      n_checks++; if (bus.valid_D !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_valid: got %b expected 0", bus.valid_D); end
      n_checks++; if (bus.pc_D !== 64'd0) begin n_fail++; $display("[TB] FAIL flush_pc: got %0d expected 0", bus.pc_D); end
      drive(1'b1, 64'd10016, 1'b0, 1'b0);
      cycle();
      n_checks++; if (bus.pc_D !== 64'd10016) begin n_fail++; $display("[TB] FAIL flush_refill_pc: got %0d expected 10016", bus.pc_D); end
      n_checks++; if (bus.count_Q !== 3'd1) begin n_fail++; $display("[TB] FAIL flush_refill_count: got %0d expected 1", bus.count_Q); end
      // Flush on an already empty queue leaves it empty and usable.
      drive(1'b0, 64'd0, 1'b1, 1'b0);
      cycle();
      drive(1'b0, 64'd0, 1'b0, 1'b1);
      cycle();
      n_checks++; if (bus.count_Q !== 3'd0) begin n_fail++; $display("[TB] FAIL flush_empty_count: got %0d expected 0", bus.count_Q); end
      drive(1'b1, 64'd500, 1'b0, 1'b0);
      cycle();
      n_checks++; if (bus.pc_D !== 64'd500) begin n_fail++; $display("[TB] FAIL flush_empty_pc: got %0d expected 500", bus.pc_D); end
      drive(1'b0, 64'd0, 1'b1, 1'b0);
      cycle();
   endtask

   task automatic test_full_with_pop();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 64'(200 + 4 * i), 1'b0, 1'b0);
         cycle();
      end
      n_checks++; if (bus.ready_F !== 1'b0) begin n_fail++; $display("[TB] FAIL fullpop_ready_F: got %b expected 0", bus.ready_F); end
      drive(1'b1, 64'd216, 1'b1, 1'b0);
      cycle();
      n_checks++; if (bus.count_Q !== 3'd3) begin n_fail++; $display("[TB] FAIL fullpop_count1: got %0d expected 3", bus.count_Q); end
      n_checks++; if (bus.pc_D !== 64'd204) begin n_fail++; $display("[TB] FAIL fullpop_pc1: got %0d expected 204", bus.pc_D); end
      drive(1'b1, 64'd216, 1'b1, 1'b0);
      cycle();
      n_checks++; if (bus.count_Q !== 3'd3) begin n_fail++; $display("[TB] FAIL fullpop_count2: got %0d expected 3", bus.count_Q); end
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 64'd0, 1'b1, 1'b0);
         n_checks++; if (bus.pc_D !== 64'(208 + 4 * k)) begin n_fail++; $display("[TB] FAIL fullpop_drain_pc_%0d: got %0d expected %0d", k, bus.pc_D, 208 + 4 * k); end
         cycle();
      end
      n_checks++; if (bus.count_Q !== 3'd0) begin n_fail++; $display("[TB] FAIL fullpop_end_count: got %0d expected 0", bus.count_Q); end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 64'(600 + 4 * i), 1'b0, 1'b0);
         cycle();
      end
      n_checks++; if (bus.count_Q !== 3'd3) begin n_fail++; $display("[TB] FAIL areset_pre_count: got %0d expected 3", bus.count_Q); end
      drive(1'b0, 64'd0, 1'b0, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      n_checks++; if (bus.count_Q !== 3'd0) begin n_fail++; $display("[TB] FAIL areset_count: got %0d expected 0", bus.count_Q); end
      n_checks++; if (bus.valid_D !== 1'b0) begin n_fail++; $display("[TB] FAIL areset_valid: got %b expected 0", bus.valid_D); end
      n_checks++; if (bus.ready_F !== 1'b1) begin n_fail++; $display("[TB] FAIL areset_ready: got %b expected 1", bus.ready_F); end
      n_checks++; if (bus.pc_D !== 64'd0) begin n_fail++; $display("[TB] FAIL areset_pc: got %0h expected 0", bus.pc_D); end
      model_q.delete();
      #2;
      reset = 1'b0;
      @(posedge clk);
      #1;
      // Reset with a full queue.
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 64'(700 + 4 * i), 1'b0, 1'b0);
         cycle();
      end
      n_checks++; if (bus.count_Q !== 3'd4) begin n_fail++; $display("[TB] FAIL areset_full_pre: got %0d expected 4", bus.count_Q); end
      drive(1'b0, 64'd0, 1'b0, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      n_checks++; if (bus.count_Q !== 3'd0) begin n_fail++; $display("[TB] FAIL areset_full_count: got %0d expected 0", bus.count_Q); end
      n_checks++; if (bus.instr_D !== 32'd0) begin n_fail++; $display("[TB] FAIL areset_full_instr: got %0h expected 0", bus.instr_D); end
      model_q.delete();
      #2;
      reset = 1'b0;
      @(posedge clk);
      #1;
      drive(1'b1, 64'd800, 1'b0, 1'b0);
      cycle();
      n_checks++; if (bus.pc_D !== 64'd800) begin n_fail++; $display("[TB] FAIL areset_resume_pc: got %0d expected 800", bus.pc_D); end
      n_checks++; if (bus.count_Q !== 3'd1) begin n_fail++; $display("[TB] FAIL areset_resume_count: got %0d expected 1", bus.count_Q); end
      drive(1'b0, 64'd0, 1'b1, 1'b0);
      cycle();
   endtask

   task automatic test_random();
      int ready_bias;
      for (int n = 0; n < 400; n++) begin
         // Alternate between phases that favour filling and draining.
         ready_bias      = ((n / 50) % 2 == 0) ? 4 : 1;
         bus.valid_F     = ($urandom_range(0, 3) != 0);
         bus.imem_addr_F = {$urandom, $urandom};
         bus.instr_F     = $urandom;
         bus.ready_D     = ($urandom_range(0, 4) < ready_bias);
         bus.flush_D     = ($urandom_range(0, 19) == 0);
         #1;
         n_checks++; if (bus.count_Q !== CW'(model_q.size())) begin n_fail++; $display("[TB] FAIL rand_count_%0d: got %0d expected %0d", n, bus.count_Q, model_q.size()); end
         n_checks++; if (bus.valid_D !== (model_q.size() > 0)) begin n_fail++; $display("[TB] FAIL rand_valid_%0d: got %b expected %b", n, bus.valid_D, model_q.size() > 0); end
         n_checks++; if (bus.ready_F !== (model_q.size() < DEPTH)) begin n_fail++; $display("[TB] FAIL rand_ready_%0d: got %b expected %b", n, bus.ready_F, model_q.size() < DEPTH); end
         n_checks++; if (bus.pc_D !== exp_pc()) begin n_fail++; $display("[TB] FAIL rand_pc_%0d: got %0h expected %0h", n, bus.pc_D, exp_pc()); end
         n_checks++; if (bus.instr_D !== exp_instr()) begin n_fail++; $display("[TB] FAIL rand_instr_%0d: got %0h expected %0h", n, bus.instr_D, exp_instr()); end
         cycle();
      end
   endtask

   initial begin
      $display("[TB] fetch_queue bench starting");
      test_reset();
      test_fill();
      test_drain();
      test_streaming();
      test_flush();
      test_full_with_pop();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
